// File: rtl/mine_pkg.sv
// Shared types and tile-grid constants for the mine hit tracker.
// Pixel coordinates are 11 bits; tiles are 2**TILE_SHIFT pixels square.
package mine_pkg;

    localparam int TILE_SHIFT = 5;

    typedef logic [10:0] pix_t;
    typedef logic [4:0]  tile_x_t;
    typedef logic [3:0]  tile_y_t;
    typedef logic [3:0]  level_t;

    localparam pix_t TILES_X = 11'd20;
    localparam pix_t TILES_Y = 11'd15;

    typedef enum logic [1:0] {
        ARMED,
        REPORT,
        LOCKOUT
    } hit_state_e;

    function automatic pix_t tile_of(pix_t p);
        return p >> TILE_SHIFT;
    endfunction

endpackage

// File: rtl/tile_window_match.sv
// Holds the latched hit tile and its clear window.
// Emits a registered collision strobe while the scan is inside that tile.
module tile_window_match
    import mine_pkg::*;
(
    input  logic    clk,
    input  logic    resetN,
    input  logic    set_i,
    input  logic    clear_i,
    input  tile_x_t tile_x_i,
    input  tile_y_t tile_y_i,
    input  pix_t    pixel_x_i,
    input  pix_t    pixel_y_i,
    output tile_x_t tile_x_o,
    output tile_y_t tile_y_o,
    output logic    collision_o
);

    tile_x_t tile_x_q, tile_x_d;
    tile_y_t tile_y_q, tile_y_d;
    logic    win_q, win_d;
    logic    coll_q, coll_d;
    logic    match;

    assign match = (tile_of(pixel_x_i) == pix_t'(tile_x_q))
                && (tile_of(pixel_y_i) == pix_t'(tile_y_q));

    always_comb begin
        tile_x_d = tile_x_q;
        tile_y_d = tile_y_q;
        win_d    = win_q;
        if (set_i) begin
            tile_x_d = tile_x_i;
            tile_y_d = tile_y_i;
            win_d    = 1'b1;
        end else if (clear_i) begin
            win_d    = 1'b0;
        end
        // The closing event already masks its own cycle.
        coll_d = win_q & ~clear_i & match;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tile_x_q <= '0;
            tile_y_q <= '0;
            win_q    <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            tile_x_q <= tile_x_d;
            tile_y_q <= tile_y_d;
            win_q    <= win_d;
            coll_q   <= coll_d;
        end
    end

    assign tile_x_o    = tile_x_q;
    assign tile_y_o    = tile_y_q;
    assign collision_o = coll_q;

endmodule

// File: rtl/mine_hit_tracker.sv
// Detects player/mine overlap, reports one hit per frame to the controller,
// drives the matrix clear strobe for the hit tile and counts hits per level.
module mine_hit_tracker
    import mine_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic [10:0]      pixelX,
    input  logic [10:0]      pixelY,
    input  logic             mineDR,
    input  logic             playerDR,
    input  logic [3:0]       level,
    input  logic             hitAck,
    output logic             collision,
    output logic             hitValid,
    output logic [4:0]       hitTileX,
    output logic [3:0]       hitTileY,
    output logic [3:0]       hitLevel,
    output logic [CNT_W-1:0] hitCount
);

    hit_state_e       state_q, state_d;
    pix_t             px_q, py_q;
    level_t           prev_lvl_q;
    level_t           hit_lvl_q, hit_lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    pix_t tx, ty;
    logic in_grid;
    logic lvl_chg;
    logic hit;

    assign tx      = tile_of(px_q);
    assign ty      = tile_of(py_q);
    assign in_grid = (tx < TILES_X) && (ty < TILES_Y);
    assign lvl_chg = (level != prev_lvl_q);

    // Frame start and level change both pre-empt a same-cycle overlap.
    assign hit = (state_q == ARMED) & mineDR & playerDR & in_grid
               & ~startOfFrame & ~lvl_chg;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARMED: begin
                if (lvl_chg) begin
                    state_d = LOCKOUT;
                end else if (hit) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (hitAck) begin
                    state_d = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (startOfFrame) begin
                    state_d = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    always_comb begin
        hitValid = (state_q == REPORT);
    end

    always_comb begin
        hit_lvl_d = hit_lvl_q;
        cnt_d     = cnt_q;
        if (hit) begin
            hit_lvl_d = level;
        end
        if (lvl_chg) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            px_q       <= '0;
            py_q       <= '0;
            prev_lvl_q <= '0;
            hit_lvl_q  <= '0;
            cnt_q      <= '0;
        end else begin
            px_q       <= pixelX;
            py_q       <= pixelY;
            prev_lvl_q <= level;
            hit_lvl_q  <= hit_lvl_d;
            cnt_q      <= cnt_d;
        end
    end

    tile_window_match u_win (
        .clk         (clk),
        .resetN      (resetN),
        .set_i       (hit),
        .clear_i     (startOfFrame | lvl_chg),
        .tile_x_i    (tile_x_t'(tx[4:0])),
        .tile_y_i    (tile_y_t'(ty[3:0])),
        .pixel_x_i   (pixelX),
        .pixel_y_i   (pixelY),
        .tile_x_o    (hitTileX),
        .tile_y_o    (hitTileY),
        .collision_o (collision)
    );

    assign hitLevel = hit_lvl_q;
    assign hitCount = cnt_q;

endmodule

// File: tb/tb_mine_hit_tracker.sv
// Directed bench for mine_hit_tracker with a cycle-level reference model
// and hand-computed literal expectations.
module tb_mine_hit_tracker;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        mineDR = 1'b0;
    logic        playerDR = 1'b0;
    logic [3:0]  level = '0;
    logic        hitAck = 1'b0;
    logic        collision;
    logic        hitValid;
    logic [4:0]  hitTileX;
    logic [3:0]  hitTileY;
    logic [3:0]  hitLevel;
    logic [7:0]  hitCount;

    mine_hit_tracker #(.CNT_W(8)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .mineDR       (mineDR),
        .playerDR     (playerDR),
        .level        (level),
        .hitAck       (hitAck),
        .collision    (collision),
        .hitValid     (hitValid),
        .hitTileX     (hitTileX),
        .hitTileY     (hitTileY),
        .hitLevel     (hitLevel),
        .hitCount     (hitCount)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a pending report, a per-frame block, a clear window.
    int m_prev_x, m_prev_y, m_prev_lvl;
    bit m_pend, m_block, m_win, m_coll;
    int m_tx, m_ty, m_lvl, m_cnt;

    int  tx, ty;
    bit  lc, ov, accept, ackd, o_pend, o_block;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_prev_x = 0; m_prev_y = 0; m_prev_lvl = 0;
            m_pend = 0; m_block = 0; m_win = 0; m_coll = 0;
            m_tx = 0; m_ty = 0; m_lvl = 0; m_cnt = 0;
        end else begin
            tx      = m_prev_x / 32;
            ty      = m_prev_y / 32;
            lc      = (int'(level) != m_prev_lvl);
            ov      = mineDR && playerDR && tx < 20 && ty < 15;
            o_pend  = m_pend;
            o_block = m_block;
            accept  = !o_pend && !o_block && ov && !startOfFrame && !lc;
            ackd    = o_pend && hitAck;
            m_coll  = m_win && !startOfFrame && !lc
                   && (int'(pixelX) / 32 == m_tx)
                   && (int'(pixelY) / 32 == m_ty);
            if (accept) begin
                m_pend = 1; m_block = 1;
                m_tx = tx; m_ty = ty; m_lvl = int'(level);
            end else if (ackd) begin
                m_pend = 0;
            end else if (!o_pend && o_block && startOfFrame) begin
                m_block = 0;
            end else if (!o_pend && !o_block && lc) begin
                m_block = 1;
            end
            if (accept) m_win = 1;
            else if (startOfFrame || lc) m_win = 0;
            if (lc) m_cnt = 0;
            else if (accept && m_cnt < 255) m_cnt = m_cnt + 1;
            m_prev_x = int'(pixelX);
            m_prev_y = int'(pixelY);
            m_prev_lvl = int'(level);
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        cmp("model.hitValid", int'(hitValid), int'(m_pend));
        cmp("model.hitTileX", int'(hitTileX), m_tx);
        cmp("model.hitTileY", int'(hitTileY), m_ty);
        cmp("model.hitLevel", int'(hitLevel), m_lvl);
        cmp("model.hitCount", int'(hitCount), m_cnt);
        cmp("model.collision", int'(collision), int'(m_coll));
    endtask

    task automatic cyc(input int x, input int y, input bit o,
                       input bit s, input bit a);
        pixelX = 11'(x);
        pixelY = 11'(y);
        mineDR = o;
        playerDR = o;
        startOfFrame = s;
        hitAck = a;
        @(negedge clk);
        check_model();
    endtask

    task automatic hit_at(input int x, input int y);
        cyc(x, y, 0, 0, 0);
        cyc(x + 1, y, 1, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, ".hitValid"}, int'(hitValid), 0);
        cmp({tag, ".collision"}, int'(collision), 0);
        cmp({tag, ".hitTileX"}, int'(hitTileX), 0);
        cmp({tag, ".hitTileY"}, int'(hitTileY), 0);
        cmp({tag, ".hitLevel"}, int'(hitLevel), 0);
        cmp({tag, ".hitCount"}, int'(hitCount), 0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        resetN = 1'b1;
        level = 4'd2;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);

        // First hit at pX_d=100, pY_d=70 -> tile (3,2)
        hit_at(100, 70);
        cmp("hit1.valid", int'(hitValid), 1);
        cmp("hit1.tileX", int'(hitTileX), 3);
        cmp("hit1.tileY", int'(hitTileY), 2);
        cmp("hit1.level", int'(hitLevel), 2);
        cmp("hit1.count", int'(hitCount), 1);
        cyc(96, 64, 0, 0, 0);
        cmp("win.in_lo", int'(collision), 1);
        cyc(95, 64, 0, 0, 0);
        cmp("win.left", int'(collision), 0);
        cyc(127, 95, 0, 0, 0);
        cmp("win.in_hi", int'(collision), 1);
        cyc(127, 96, 0, 0, 0);
        cmp("win.below", int'(collision), 0);
        cyc(128, 80, 0, 0, 0);
        cmp("win.right", int'(collision), 0);

        // Three frames without acknowledge
        for (int f = 0; f < 3; f++) begin
            cyc(0, 0, 0, 1, 0);
            cyc(100, 70, 0, 0, 0);
            cmp("win.closed", int'(collision), 0);
            hit_at(300, 200);
        end
        cmp("hold.valid", int'(hitValid), 1);
        cmp("hold.count", int'(hitCount), 1);
        cmp("hold.tileX", int'(hitTileX), 3);
        cyc(0, 0, 0, 0, 1);
        cmp("ack.valid", int'(hitValid), 0);
        hit_at(300, 200);
        cmp("lockout.valid", int'(hitValid), 0);
        cyc(0, 0, 0, 1, 0);
        hit_at(200, 100);
        cmp("hit2.count", int'(hitCount), 2);
        cmp("hit2.tileX", int'(hitTileX), 6);
        cmp("hit2.tileY", int'(hitTileY), 3);
        cyc(0, 0, 0, 0, 1);

        // startOfFrame with overlap, stray ack, out-of-grid overlaps
        cyc(0, 0, 0, 1, 0);
        cyc(200, 100, 0, 0, 0);
        cyc(201, 100, 1, 1, 0);
        cmp("sof_ov.valid", int'(hitValid), 0);
        cmp("sof_ov.count", int'(hitCount), 2);
        cyc(0, 0, 0, 0, 1);
        cmp("stray_ack.valid", int'(hitValid), 0);
        hit_at(700, 70);
        cmp("oob_x.valid", int'(hitValid), 0);
        hit_at(100, 500);
        cmp("oob_y.valid", int'(hitValid), 0);
        hit_at(639, 479);
        cmp("edge.valid", int'(hitValid), 1);
        cmp("edge.tileX", int'(hitTileX), 19);
        cmp("edge.tileY", int'(hitTileY), 14);
        cmp("edge.count", int'(hitCount), 3);
        cyc(0, 0, 0, 0, 1);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            cyc(0, 0, 0, 1, 0);
            hit_at(40, 40);
            cyc(0, 0, 0, 0, 1);
        end
        cmp("sat.count", int'(hitCount), 255);
        level = 4'd3;
        cyc(0, 0, 0, 0, 0);
        cmp("lvl3.count", int'(hitCount), 0);

        // Level change while a report is pending
        level = 4'd2;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        hit_at(100, 70);
        cmp("hit3.count", int'(hitCount), 1);
        level = 4'd3;
        cyc(100, 70, 0, 0, 0);
        cmp("lvlchg.collision", int'(collision), 0);
        cmp("lvlchg.valid", int'(hitValid), 1);
        cmp("lvlchg.level", int'(hitLevel), 2);
        cmp("lvlchg.count", int'(hitCount), 0);
        cyc(110, 80, 0, 0, 0);
        cmp("lvlchg.collision2", int'(collision), 0);

        // Reset while reporting with collision active
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        hit_at(100, 70);
        cyc(100, 70, 0, 0, 0);
        cmp("pre_rst.collision", int'(collision), 1);
        #2 resetN = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        resetN = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        hit_at(500, 300);
        cmp("post_rst.valid", int'(hitValid), 1);
        cmp("post_rst.tileX", int'(hitTileX), 15);
        cmp("post_rst.tileY", int'(hitTileY), 9);
        cmp("post_rst.level", int'(hitLevel), 3);
        cmp("post_rst.count", int'(hitCount), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
